// File: rtl/load_pkg.sv
// load_pkg: shared funct3 codes, FSM state encoding and alignment helper for the load path.
package load_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Halfwords need an even address, words need a 4-byte aligned address.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3 == F3_LH || f3 == F3_LHU) && off[0]) || (f3 == F3_LW && off != 2'b00);
    endfunction

endpackage

// File: rtl/load_extract.sv
// load_extract: selects the addressed byte/halfword of a little-endian word and extends it per funct3.
module load_extract
    import load_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        illegal
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b       = rdata[{off, 3'b000} +: 8];
        h       = off[1] ? rdata[31:16] : rdata[15:0];
        illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        data    = funct3 == F3_LB  ? {{24{b[7]}}, b}  :
                  funct3 == F3_LH  ? {{16{h[15]}}, h} :
                  funct3 == F3_LW  ? rdata            :
                  funct3 == F3_LBU ? {24'b0, b}       :
                  funct3 == F3_LHU ? {16'b0, h}       : 32'b0;
    end

endmodule

// File: rtl/load_extend_ctrl.sv
// load_extend_ctrl: single-outstanding RV32I load unit: word read, byte/half extraction, valid/ready response.
// Optional misalignment trap enabled by defining LOAD_MISALIGN_TRAP_EN.
module load_extend_ctrl
    import load_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    state_t             state, state_d;
    logic [31:0]        addr_q, addr_d, data_q, data_d, ext_data;
    logic [2:0]         f3_q, f3_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               err_q, err_d, ext_illegal, trap;

    // The extractor also screens the incoming funct3 while idle, so it sees the live request then.
    load_extract u_extract (
        .rdata   (mem_rdata),
        .off     (addr_q[1:0]),
        .funct3  (state == IDLE ? req_funct3 : f3_q),
        .data    (ext_data),
        .illegal (ext_illegal)
    );

`ifdef LOAD_MISALIGN_TRAP_EN
    assign trap = misaligned(req_funct3, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign req_ready = state == IDLE && !reset;
    assign mem_rd_en = state == ISSUE;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign rsp_valid = state == RESP;
    assign rsp_data  = data_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state;
        addr_d  = addr_q;
        f3_d    = f3_q;
        cnt_d   = cnt;
        data_d  = data_q;
        err_d   = err_q;
        case (state)
            IDLE: if (req_valid) begin
                addr_d  = req_addr;
                f3_d    = req_funct3;
                data_d  = 32'b0;
                err_d   = ext_illegal || trap;
                state_d = (ext_illegal || trap) ? RESP : ISSUE;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (mem_rvalid) begin
                data_d  = ext_data;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                data_d  = 32'b0;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d   = cnt + CNT_W'(1);
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            addr_q <= 32'b0;
            f3_q   <= 3'b0;
            cnt    <= '0;
            data_q <= 32'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_d;
            addr_q <= addr_d;
            f3_q   <= f3_d;
            cnt    <= cnt_d;
            data_q <= data_d;
            err_q  <= err_d;
        end
    end

endmodule

// File: doc/load_extend_ctrl.md
Name: load_extend_ctrl

Overview:
- Read-side counterpart to the store byte-merge path: accepts one RV32I load request at a time and issues a word-aligned read to synchronous data memory.
- Waits for read data, then selects the addressed byte or halfword (little endian) and sign- or zero-extends it per funct3.
- Returns the result to the writeback stage over a valid/ready handshake.
- Sits between the execute/memory stage and the data-memory read port.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in WAIT before the request completes with error; must be >= 1.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  load request present
- req_ready  out  1  block can accept request (high only in IDLE)
- req_addr  in  32  byte address of load
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others illegal
- mem_rd_en  out  1  one-cycle read strobe to data memory
- mem_addr  out  32  {addr[31:2],2'b00}
- mem_rvalid  in  1  read data valid from memory
- mem_rdata  in  32  read word
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  32  extended load result
- rsp_err  out  1  response is an error (illegal funct3, timeout, misaligned); rsp_data=0 when set

Behaviour:
- Reset is synchronous and active-high. Under reset: state=IDLE; req_ready=0 during the reset cycle and 1 afterwards; mem_rd_en=0; mem_addr=0; rsp_valid=0; rsp_data=0; rsp_err=0; counter=0.
- Reset mid-operation abandons the request. A mem_rvalid arriving afterwards is ignored.
- States and transitions:
  - IDLE: req_ready=1. On req_valid, latch addr and funct3.
    - Illegal funct3 -> RESP with err; no memory access.
    - Misaligned access with the macro enabled -> RESP with err; no memory access.
    - Otherwise -> ISSUE.
  - ISSUE: mem_rd_en=1 for exactly this cycle; mem_addr driven from the latched address and held until leaving WAIT. -> WAIT; counter cleared.
  - WAIT: mem_rvalid is sampled starting in the cycle after ISSUE.
    - On mem_rvalid: register the extracted data -> RESP with err=0.
    - Otherwise the counter increments. When counter==TIMEOUT_CYCLES-1 with no rvalid -> RESP with err=1 and data=0.
  - RESP: rsp_valid=1; rsp_data and rsp_err held stable until rsp_ready. On rsp_valid&rsp_ready -> IDLE.
    - mem_rvalid received in RESP or IDLE (a late reply) is dropped.
- Minimum latency: request accepted at edge 0, ISSUE in cycle 1, rvalid in cycle 2, rsp_valid in cycle 3. Throughput is one load per ≥4 cycles; there is no overlap.
- Extraction, with off = addr[1:0]:
  - byte = mem_rdata[8*off +: 8]
  - half = mem_rdata[16*off[1] +: 16]
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word unchanged.
- Alignment without the macro:
  - LH/LHU ignore addr[0].
  - LW ignores addr[1:0].
  - No error is raised.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- Defined: a misaligned access completes with rsp_err=1, rsp_data=0, and mem_rd_en never asserted. Misaligned means LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
- Undefined: no misalignment check; the low address bits are truncated as described under Behaviour.

Decomposition:
- Shared package load_pkg holds:
  - funct3 localparams F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU
  - state encoding IDLE/ISSUE/WAIT/RESP (2-bit)
- Natural sub-module: load_extract, purely combinational (mem_rdata, off, funct3 -> extended data, illegal flag). It is reused by any future cache refill path.

Test Plan:
- LB, addr 0x02000005, mem word 0x1234AB78, rvalid one cycle after ISSUE -> rsp_data=0xFFFFFFAB, err=0, rsp_valid in cycle 3. LBU at the same address -> 0x000000AB.
- LH, addr 0x02000006, word 0x80010000 -> 0xFFFF8001. LHU -> 0x00008001. mem_addr=0x02000004 in both cases.
- LW, addr 0x02000008, rvalid delayed 5 cycles, rsp_ready low 3 cycles -> exactly one mem_rd_en pulse; rsp_data stable and equal to mem_rdata; req_ready stays 0 until the handshake.
- Error paths:
  - funct3=011 -> RESP err=1, data=0, no mem_rd_en.
  - No rvalid for TIMEOUT_CYCLES -> err=1; a late rvalid in IDLE is ignored.
- With LOAD_MISALIGN_TRAP_EN: LW at 0x02000002 -> err=1, no mem_rd_en. Without the macro: the same request returns the word at 0x02000000.
- reset asserted in WAIT -> next cycle IDLE, all outputs 0 except req_ready=1 after release; a following rvalid produces no response.
